// File: rtl/demux_1_to_2_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer and its sibling
// datapath blocks: slot occupancy encoding and default port widths.
package demux_1_to_2_buf_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   localparam int DATA_W_DEFAULT = 32;
   localparam int CNT_W_DEFAULT  = 8;

endpackage : demux_1_to_2_buf_pkg

// File: rtl/demux_1_to_2_buf_out_slot.sv
// One-entry output slot with a valid/ready consumer port and a wrapping
// count of completed consumer handshakes.
module demux_out_slot
   import demux_1_to_2_buf_pkg::*;
#(
   parameter int size  = DATA_W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [size-1:0]  load_data_i,
   input  logic             ready_i,
   output logic [size-1:0]  data_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o
);

   slot_state_e      state_q, state_d;
   logic [size-1:0]  data_q,  data_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             drain_s;

   // Next slot state: a load wins over a simultaneous drain, but the drain still counts
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      drain_s = (state_q == SLOT_FULL) & ready_i;
      if (drain_s) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
      if (load_i) begin
         state_d = SLOT_FULL;
         data_d  = load_data_i;
      end else if (drain_s) begin
         state_d = SLOT_EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   // Slot registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= SLOT_EMPTY;
         data_q  <= {size{1'b0}};
         count_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = (state_q == SLOT_FULL);
   assign count_o = count_q;

endmodule : demux_out_slot

// File: rtl/demux_1_to_2_buf.sv
// Registered 1-to-2 demultiplexer: one producer stream steered per transfer
// into one of two independent one-entry output slots.
module demux_1_to_2_buf
   import demux_1_to_2_buf_pkg::*;
#(
   parameter int size  = DATA_W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [size-1:0]  data_i,
   input  logic             select_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [size-1:0]  data0_o,
   output logic             valid0_o,
   input  logic             ready0_i,
   output logic [size-1:0]  data1_o,
   output logic             valid1_o,
   input  logic             ready1_i,
   output logic [CNT_W-1:0] count0_o,
   output logic [CNT_W-1:0] count1_o
);

   logic ready_s;
   logic load0_s;
   logic load1_s;
   logic valid0_s;
   logic valid1_s;

   // Ready reflects only the selected slot, so a stalled sink blocks only its own traffic
   always_comb begin
      ready_s = 1'b0;
      load0_s = 1'b0;
      load1_s = 1'b0;
      if (select_i) begin
         ready_s = ~valid1_s | ready1_i;
      end else begin
         ready_s = ~valid0_s | ready0_i;
      end
      load0_s = valid_i & ready_s & ~select_i;
      load1_s = valid_i & ready_s &  select_i;
   end

   assign ready_o  = ready_s;
   assign valid0_o = valid0_s;
   assign valid1_o = valid1_s;

   demux_out_slot #(.size(size), .CNT_W(CNT_W)) u_slot0 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load0_s),
      .load_data_i (data_i),
      .ready_i     (ready0_i),
      .data_o      (data0_o),
      .valid_o     (valid0_s),
      .count_o     (count0_o)
   );

   demux_out_slot #(.size(size), .CNT_W(CNT_W)) u_slot1 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load1_s),
      .load_data_i (data_i),
      .ready_i     (ready1_i),
      .data_o      (data1_o),
      .valid_o     (valid1_s),
      .count_o     (count1_o)
   );

endmodule : demux_1_to_2_buf

// File: tb/tb_demux_1_to_2_buf.sv
// Randomized scoreboard bench for demux_1_to_2_buf: per-destination FIFOs of
// accepted words, a decoupled output monitor, and reset checks.
module tb_demux_1_to_2_buf;

   localparam int W  = 32;
   localparam int CW = 8;
   localparam int N_CYC   = 3000;
   localparam int N_DRAIN = 20;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [W-1:0]  data_i;
   logic          select_i;
   logic          valid_i;
   logic          ready_o;
   logic [W-1:0]  data0_o;
   logic          valid0_o;
   logic          ready0_i;
   logic [W-1:0]  data1_o;
   logic          valid1_o;
   logic          ready1_i;
   logic [CW-1:0] count0_o;
   logic [CW-1:0] count1_o;

   int tests  = 0;
   int errors = 0;

   // Reference: words accepted for each destination and not yet consumed, in order.
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   int  pend0 = 0;
   int  pend1 = 0;
   int  cnt0  = 0;
   int  cnt1  = 0;
   bit  mon_en = 1'b0;

   demux_1_to_2_buf #(.size(W), .CNT_W(CW)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .select_i (select_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data0_o  (data0_o),
      .valid0_o (valid0_o),
      .ready0_i (ready0_i),
      .data1_o  (data1_o),
      .valid1_o (valid1_o),
      .ready1_i (ready1_i),
      .count0_o (count0_o),
      .count1_o (count1_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares slot outputs against the scoreboard at each falling edge.
   initial begin
      int res;
      forever begin
         @(negedge clk_i);
         if (mon_en) begin
            res = q0.size() - pend0;
            chk("valid0", valid0_o, res > 0);
            chk("count0", count0_o, cnt0 % 256);
            if (valid0_o && res > 0) begin
               chk("data0", data0_o, q0[0]);
               if (ready0_i) begin
                  void'(q0.pop_front());
                  cnt0++;
               end
            end
            pend0 = 0;
            res = q1.size() - pend1;
            chk("valid1", valid1_o, res > 0);
            chk("count1", count1_o, cnt1 % 256);
            if (valid1_o && res > 0) begin
               chk("data1", data1_o, q1[0]);
               if (ready1_i) begin
                  void'(q1.pop_front());
                  cnt1++;
               end
            end
            pend1 = 0;
         end
      end
   end

   // Driver: random producer honouring the hold-until-accept rule, random sinks.
   initial begin
      bit hold;
      int res;
      bit exp_rdy;
      rst_i    = 1'b0;
      data_i   = 32'h0;
      select_i = 1'b0;
      valid_i  = 1'b0;
      ready0_i = 1'b0;
      ready1_i = 1'b0;
      hold     = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid0", valid0_o, 1'b0);
      chk("rst_valid1", valid1_o, 1'b0);
      chk("rst_data0",  data0_o, 32'h0);
      chk("rst_data1",  data1_o, 32'h0);
      chk("rst_count0", count0_o, 8'h0);
      chk("rst_count1", count1_o, 8'h0);
      chk("rst_ready",  ready_o, 1'b1);
      rst_i  = 1'b1;
      mon_en = 1'b1;

      for (int c = 0; c < N_CYC + N_DRAIN; c++) begin
         @(posedge clk_i);
         #1;
         if (!hold) begin
            valid_i  = (c < N_CYC) ? ($urandom_range(0, 3) != 0) : 1'b0;
            select_i = $urandom_range(0, 1);
            data_i   = $urandom;
         end
         ready0_i = (c >= N_CYC) ? 1'b1 : ($urandom_range(0, 3) != 0);
         ready1_i = (c >= N_CYC) ? 1'b1 : ($urandom_range(0, 1) != 0);
         #1;
         res     = select_i ? q1.size() : q0.size();
         exp_rdy = (res == 0) || (select_i ? ready1_i : ready0_i);
         chk("ready_o", ready_o, exp_rdy);
         if (valid_i && exp_rdy) begin
            if (select_i) begin
               q1.push_back(data_i);
               pend1 = 1;
            end else begin
               q0.push_back(data_i);
               pend0 = 1;
            end
            hold = 1'b0;
         end else begin
            hold = valid_i;
         end
      end
      mon_en = 1'b0;

      // Fill slot 0 then reset asynchronously between edges.
      valid_i  = 1'b1;
      select_i = 1'b0;
      data_i   = 32'hDEAD_BEEF;
      ready0_i = 1'b0;
      ready1_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("pre_rst_valid0", valid0_o, 1'b1);
      chk("pre_rst_data0",  data0_o, 32'hDEAD_BEEF);
      #3;
      rst_i = 1'b0;
      #1;
      chk("async_valid0", valid0_o, 1'b0);
      chk("async_data0",  data0_o, 32'h0);
      chk("async_count0", count0_o, 8'h0);
      chk("async_count1", count1_o, 8'h0);
      #2;
      rst_i = 1'b1;
      #1;
      chk("post_rst_ready", ready_o, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_demux_1_to_2_buf
